// File: rtl/cbi980_regarb.sv
// Register-port arbiter and boot sequencer for the CBI980 core: replays an init
// write table after reset, then shares the core port between m0 and m1 round-robin.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_INIT | stream init table entries into the core, one per cycle
// S_IDLE | arbitrate between m0/m1 and latch the granted access
// S_WR   | core write strobe active, sampling c_wr_err
// S_RD   | core read strobe active until valid_out or timeout
// S_ACK  | one-cycle completion pulse to the granted master
module cbi980_regarb #(
    parameter int unsigned  INIT_LEN   = 4,
    parameter logic [23:0]  INIT_ADDR  = 24'h0,
    parameter logic [255:0] INIT_DATA  = 256'h0,
    parameter int unsigned  RD_TIMEOUT = 64
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  c_wr_addr,
    output logic [31:0] c_wr_data,
    output logic        c_wr_en,
    input  logic        c_wr_err,
    output logic [2:0]  c_rd_addr,
    output logic        c_rd_valid_in,
    input  logic [31:0] c_rd_data,
    input  logic        c_rd_valid_out
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_ACK} state_t;

    localparam logic [3:0] LEN   = 4'(INIT_LEN);
    localparam logic [7:0] RD_TO = 8'(RD_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        init_done_q, init_done_d;
    logic        init_err_q, init_err_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        rd_vin_q, rd_vin_d;
    logic [2:0]  rd_addr_q, rd_addr_d;
    logic        m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic        sel, sel_we;
    logic [2:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        do_ack, ack_err;
    logic [31:0] ack_rdata;

    // On a tie the master that was not granted last wins.
    assign sel       = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        init_err_d   = init_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        rd_vin_d     = 1'b0;
        rd_addr_d    = '0;
        do_ack       = 1'b0;
        ack_err      = 1'b0;
        ack_rdata    = '0;
        case (state_q)
            S_INIT: begin
                if (wr_en_q && c_wr_err) init_err_d = 1'b1;
                if (idx_q < LEN) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = INIT_ADDR[int'(idx_q[2:0]) * 3 +: 3];
                    wr_data_d = INIT_DATA[int'(idx_q[2:0]) * 32 +: 32];
                    idx_d     = idx_q + 4'd1;
                end else begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    addr_d       = sel_addr;
                    if (sel_we) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_wdata;
                        state_d   = S_WR;
                    end else begin
                        rd_vin_d  = 1'b1;
                        rd_addr_d = sel_addr;
                        cnt_d     = '0;
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                do_ack  = 1'b1;
                ack_err = c_wr_err;
                state_d = S_ACK;
            end
            S_RD: begin
                // A late valid_out landing on the timeout cycle still delivers data.
                if (c_rd_valid_out) begin
                    do_ack    = 1'b1;
                    ack_rdata = c_rd_data;
                    cnt_d     = '0;
                    state_d   = S_ACK;
                end else if (cnt_q + 8'd1 == RD_TO) begin
                    do_ack    = 1'b1;
                    ack_err   = 1'b1;
                    ack_rdata = 32'hDEAD_BEEF;
                    cnt_d     = '0;
                    state_d   = S_ACK;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    rd_vin_d  = 1'b1;
                    rd_addr_d = addr_q;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        m0_ack_d   = do_ack && !gnt_q;
        m1_ack_d   = do_ack && gnt_q;
        m0_err_d   = m0_ack_d ? ack_err   : m0_err_q;
        m0_rdata_d = m0_ack_d ? ack_rdata : m0_rdata_q;
        m1_err_d   = m1_ack_d ? ack_err   : m1_err_q;
        m1_rdata_d = m1_ack_d ? ack_rdata : m1_rdata_q;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            init_err_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_vin_q     <= 1'b0;
            rd_addr_q    <= '0;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            init_err_q   <= init_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_vin_q     <= rd_vin_d;
            rd_addr_q    <= rd_addr_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_ack        = m0_ack_q;
    assign m0_err        = m0_err_q;
    assign m0_rdata      = m0_rdata_q;
    assign m1_ack        = m1_ack_q;
    assign m1_err        = m1_err_q;
    assign m1_rdata      = m1_rdata_q;
    assign init_done     = init_done_q;
    assign init_err      = init_err_q;
    assign c_wr_en       = wr_en_q;
    assign c_wr_addr     = wr_addr_q;
    assign c_wr_data     = wr_data_q;
    assign c_rd_valid_in = rd_vin_q;
    assign c_rd_addr     = rd_addr_q;

endmodule

// File: doc/cbi980_regarb.md
Name: cbi980_regarb

Overview:
- Register-port arbiter and boot sequencer for the CBI980 core register interface (3-bit word address, 32-bit data, write port with error flag, read port with valid-in/valid-out handshake).
- After reset, replays a parameterised init table of register writes into the core, then shares the core port between two requesters: m0 (AXI4-Lite bridge) and m1 (auxiliary master, e.g. DMA/debug).
- Sits between the bus-side FSMs and cbi980_core; one outstanding access at a time.

Parameters:
- INIT_LEN, 4, number of init writes, 0..8.
- INIT_ADDR, 24'h0, packed 8x3-bit addresses; entry i = INIT_ADDR[3i+2:3i].
- INIT_DATA, 256'h0, packed 8x32-bit data; entry i = INIT_DATA[32i+31:32i].
- RD_TIMEOUT, 64, cycles in RD before a read is aborted, 1..255.

Ports:
- aclk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- m0_req  in  1  request; held with m0_we/m0_addr/m0_wdata stable until m0_ack
- m0_we  in  1  1=write, 0=read
- m0_addr  in  3  word address
- m0_wdata  in  32  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  error qualifier, valid with m0_ack
- m0_rdata  out  32  read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0
- init_done  out  1  high once the init table has been written
- init_err  out  1  sticky: any init write returned error
- c_wr_addr  out  3  to core wr_addr
- c_wr_data  out  32  to core wr_data
- c_wr_en  out  1  to core wr_en
- c_wr_err  in  1  core write error, valid in the same cycle as c_wr_en
- c_rd_addr  out  3  to core rd_addr
- c_rd_valid_in  out  1  to core rd_valid_in
- c_rd_data  in  32  core read data, valid with c_rd_valid_out
- c_rd_valid_out  in  1  core read done

Behaviour:
- Reset (async assert, sync to aclk on release): all outputs 0, state INIT, init index 0, last_grant=1 (so m0 wins first tie), timeout counter 0.
- States: INIT, IDLE, WR, RD, ACK.
- INIT: if INIT_LEN=0, go to IDLE next cycle. Otherwise drive c_wr_en=1 with entry idx for INIT_LEN consecutive cycles, idx 0 first. Any c_wr_err during INIT sets init_err. After the last entry, go to IDLE and set init_done=1 (registered, stays 1 until reset). Requests pending during INIT are held; none are acked.
- IDLE: if m0_req only or m1_req only, grant it. If both, grant the one != last_grant (round-robin). Latch granted id, we, addr, wdata, update last_grant, go to WR if we else RD. No request: stay.
- WR: one cycle; c_wr_en=1, c_wr_addr/c_wr_data from latch; capture c_wr_err into err; go to ACK. Write latency is req-seen-in-IDLE cycle N -> c_wr_en at N+1 -> ack at N+2.
- RD: c_rd_valid_in=1 and c_rd_addr from latch every cycle until c_rd_valid_out=1 is sampled. Then capture c_rd_data, err=0, go to ACK. Counter increments each RD cycle. If the count reaches RD_TIMEOUT without valid_out: rdata=32'hDEAD_BEEF, err=1, go to ACK. If valid_out arrives in the same cycle as the timeout, valid_out wins.
- ACK: one cycle. The granted master's ack=1, with err/rdata; the other master's ack=0. Then go to IDLE. rdata=0 for writes. mX_rdata/mX_err hold their value until the next ack to that master.
- Requester rule: drop req in the cycle after ack unless issuing a new access. The arbiter re-arbitrates in the IDLE cycle that follows ACK, so back-to-back accesses are allowed; minimum spacing is 3 cycles for writes.
- c_wr_en and c_rd_valid_in are never high together and never high outside INIT/WR/RD.
- Reset mid-access: access is aborted, no ack, init table replays.

Test Plan:
- INIT_LEN=3, table {(1,0x11),(2,0x22),(5,0x55)} -> c_wr_en high 3 consecutive cycles with these addr/data in order; init_done rises the following cycle; init_err=0.
- After init, m0 write addr 3 data 0xCAFE0001, c_wr_err=0 -> c_wr_en one cycle at N+1, m0_ack at N+2 with m0_err=0.
- m1 read addr 4, core returns 0x12345678 after 3 cycles of c_rd_valid_in -> m1_ack with m1_rdata=0x12345678, m1_err=0.
- m0 and m1 request writes simultaneously and repeatedly -> grants alternate m0, m1, m0, m1; no ack ever goes to a master without a request.
- Write with c_wr_err=1 -> m0_err=1 on ack. Init entry returning error -> init_err=1, stays set.
- RD_TIMEOUT=8, core never returns valid_out -> ack after 8 RD cycles with rdata=0xDEADBEEF, err=1. Then assert arstn=0 mid-read -> no ack, outputs 0, init replays.
